// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-channel fixed/round-robin multiplexer with registered single-entry output
module rr_mux_n #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 8,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Output stage and round-robin pointer state.
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    // Arbitration results.
    logic             w_load_en;
    logic             w_rr_any;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_fix_any;
    logic             w_gnt_any;
    logic [SELW-1:0]  w_gnt_idx;
    logic [NCH-1:0]   w_grant;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_xfer;

    // The output register can take a new word when empty or when it drains this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Round-robin search starting one past the last served channel, wrapping modulo NCH.
    always_comb begin
        int j;
        w_rr_any = 1'b0;
        w_rr_idx = '0;
        j        = 0;
        for (int k = 1; k <= NCH; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!w_rr_any && in_valid[SELW'(j)]) begin
                w_rr_any = 1'b1;
                w_rr_idx = SELW'(j);
            end
        end
    end

    // Fixed selection; an out-of-range index (possible when NCH is not a power of two) grants nothing.
    always_comb begin
        w_fix_any = 1'b0;
        if (int'(sel) < NCH) begin
            w_fix_any = in_valid[sel];
        end
    end

    // Pick the active policy and expand the winning index to a one-hot grant plus its data.
    always_comb begin
        w_gnt_any  = mode ? w_rr_any : w_fix_any;
        w_gnt_idx  = mode ? w_rr_idx : sel;
        w_grant    = '0;
        w_sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_any && (w_gnt_idx == SELW'(i))) begin
                w_grant[i] = 1'b1;
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // in_ready is forced low while reset is asserted even though the empty output would allow a load.
    assign in_ready = w_grant & {NCH{w_load_en && rst_n}};
    assign w_xfer   = w_gnt_any && w_load_en;

    // Output register: load on transfer, drain when accepted, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pointer tracks the last served channel in both modes so round-robin resumes after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SELW'(NCH - 1);
        end else if (w_xfer) begin
            r_ptr <= w_gnt_idx;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_n.sv
// tb/tb_rr_mux_n.sv - directed self-checking bench for rr_mux_n (NCH=8 and NCH=5 instances)
module tb_rr_mux_n;

    logic        clk;
    logic        rst_n;

    // NCH=8 instance signals
    logic [63:0] in_data8;
    logic [7:0]  in_valid8;
    logic [7:0]  in_ready8;
    logic        mode8;
    logic [2:0]  sel8;
    logic [7:0]  out_data8;
    logic [2:0]  out_ch8;
    logic        out_valid8;
    logic        out_ready8;

    // NCH=5 instance signals
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_valid5;
    logic        out_ready5;

    int n_checks;
    int n_fail;

    rr_mux_n #(.WIDTH(8), .NCH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .mode      (mode8),
        .sel       (sel8),
        .out_data  (out_data8),
        .out_ch    (out_ch8),
        .out_valid (out_valid8),
        .out_ready (out_ready8)
    );

    rr_mux_n #(.WIDTH(8), .NCH(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_ch    (out_ch5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out8(input string tag, input int ch, input logic [7:0] data);
        check({tag, ".valid"}, 32'(out_valid8), 32'd1);
        check({tag, ".ch"},    32'(out_ch8),    32'(ch));
        check({tag, ".data"},  32'(out_data8),  32'(data));
    endtask

    initial begin
        int expch;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        mode8      = 1'b1;
        sel8       = 3'd0;
        in_valid8  = 8'hFF;
        out_ready8 = 1'b1;
        for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'h10 + 8'(i);
        mode5      = 1'b1;
        sel5       = 3'd0;
        in_valid5  = 5'b0;
        out_ready5 = 1'b1;
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h20 + 8'(i);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst.valid", 32'(out_valid8), 32'd0);
        check("rst.ch",    32'(out_ch8),    32'd0);
        check("rst.data",  32'(out_data8),  32'd0);
        check("rst.ready", 32'(in_ready8),  32'd0);
        tick();
        tick();
        check("rst.ready_held", 32'(in_ready8), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst.ready", 32'(in_ready8), 32'h01);

        // Round-robin over all channels: 0..7 then wrap to 0
        for (int s = 0; s < 9; s++) begin
            tick();
            expch = s % 8;
            check_out8($sformatf("rr%0d", s), expch, 8'h10 + 8'(expch));
            check($sformatf("rr%0d.ready", s), 32'(in_ready8), 32'(1 << ((expch + 1) % 8)));
        end

        // Sparse requesters alternate 2,5,2,5
        in_valid8 = 8'b0010_0100;
        #1;
        check("alt.ready0", 32'(in_ready8), 32'h04);
        for (int s = 0; s < 4; s++) begin
            tick();
            expch = (s % 2 == 0) ? 2 : 5;
            check_out8($sformatf("alt%0d", s), expch, 8'h10 + 8'(expch));
            check($sformatf("alt%0d.ready", s), 32'(in_ready8), (expch == 2) ? 32'h20 : 32'h04);
        end

        // Fixed select
        mode8 = 1'b0;
        sel8  = 3'd3;
        in_valid8 = 8'b0000_1000;
        in_data8[3*8 +: 8] = 8'hA5;
        #1;
        check("fix.ready", 32'(in_ready8), 32'h08);
        tick();
        check_out8("fix", 3, 8'hA5);
        in_valid8 = 8'b1111_0111;
        #1;
        check("fix_none.ready", 32'(in_ready8), 32'h00);
        tick();
        check("fix_none.valid", 32'(out_valid8), 32'd0);
        check("fix_none.ch",    32'(out_ch8),    32'd3);
        check("fix_none.data",  32'(out_data8),  32'hA5);

        // Backpressure: resume round-robin after channel 3
        in_data8[3*8 +: 8] = 8'h13;
        mode8     = 1'b1;
        in_valid8 = 8'hFF;
        #1;
        check("bp.ready0", 32'(in_ready8), 32'h10);
        tick();
        check_out8("bp.load", 4, 8'h14);
        out_ready8 = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("bp%0d.ready", s), 32'(in_ready8), 32'h00);
            tick();
            check_out8($sformatf("bp%0d", s), 4, 8'h14);
        end
        out_ready8 = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready8), 32'h20);
        tick();
        check_out8("bp.next", 5, 8'h15);

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid8), 32'd0);
        check("arst.ready", 32'(in_ready8),  32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("arst.post_ready", 32'(in_ready8), 32'h01);
        tick();
        check_out8("arst.first", 0, 8'h10);

        // NCH=5: out-of-range fixed select grants nothing
        mode5     = 1'b0;
        sel5      = 3'd6;
        in_valid5 = 5'b11111;
        #1;
        check("n5.sel6_ready", 32'(in_ready5), 32'h00);
        tick();
        check("n5.sel6_valid", 32'(out_valid5), 32'd0);

        // NCH=5: round-robin wraps 4 -> 0
        mode5 = 1'b1;
        #1;
        check("n5.rr_ready0", 32'(in_ready5), 32'h01);
        for (int s = 0; s < 6; s++) begin
            tick();
            expch = s % 5;
            check($sformatf("n5.rr%0d.valid", s), 32'(out_valid5), 32'd1);
            check($sformatf("n5.rr%0d.ch", s),    32'(out_ch5),    32'(expch));
            check($sformatf("n5.rr%0d.data", s),  32'(out_data5),  32'(8'h20 + 8'(expch)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_n.md
RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 Parameter NCH, default 8, number of input channels (2..16).
REQ-003 Derived SELW = clog2(NCH), channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  per-channel request.
REQ-008 in_ready  output  NCH  per-channel accept, one-hot or zero.
REQ-009 mode  input  1  0 = fixed select via sel, 1 = round-robin.
REQ-010 sel  input  SELW  channel index used when mode=0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SELW  index of channel that produced out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a transfer.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Output stage is a single-entry register; load_en = !out_valid || out_ready.
REQ-016 Transfer from channel i occurs when in_valid[i] && in_ready[i]; in_ready[i] = grant[i] && load_en.
REQ-017 grant is combinational; at most one bit set; zero when no eligible request.
REQ-018 mode=0: grant[sel] = in_valid[sel]; sel >= NCH grants nothing and in_ready stays 0.
REQ-019 mode=1: grant goes to first i with in_valid[i], searching ptr+1, ptr+2, ... modulo NCH.
REQ-020 ptr (SELW bits) updates to the granted index only on a transfer edge; otherwise it holds.
REQ-021 ptr also updates on mode=0 transfers, so a switch to mode=1 continues after the last served channel.
REQ-022 Mode or sel changes take effect combinationally; there is no pipeline flush.
REQ-023 On a transfer edge: out_data <= selected channel data, out_ch <= index, out_valid <= 1.
REQ-024 When out_valid && out_ready and there is no transfer, out_valid <= 0; out_data and out_ch hold their values.
REQ-025 When out_valid && !out_ready, out_data, out_ch and out_valid are held stable and every in_ready is 0.
REQ-026 Latency is 1 cycle from the transfer edge to out_valid; sustained throughput is 1 transfer per cycle when out_ready=1.
REQ-027 Round-robin fairness: with all channels requesting continuously, each channel is served once every NCH transfers.
REQ-028 in_valid deasserting without a transfer loses nothing; the block stores only granted data.

Reset
REQ-029 While rst_n=0: out_valid=0, out_data=0, out_ch=0, ptr=NCH-1 (so channel 0 has first priority); in_ready=0 as a consequence of out_valid=0 being overridden by reset.
REQ-030 An asynchronous reset mid-transfer discards any held output; the first post-reset grant follows REQ-029 priority.
REQ-031 Deassertion of rst_n is sampled synchronously; the first transfer is possible on the first rising edge after release.

Verification
REQ-032 Reset, NCH=8, WIDTH=8, mode=1, all in_valid=1, in_data[i]=8'h10+i, out_ready=1 -> out_ch sequence 0,1,...,7,0 with out_data 10..17,10 on consecutive cycles.
REQ-033 mode=1, in_valid=8'b0010_0100, out_ready=1 -> grants alternate 2,5,2,5; the in_ready one-hot matches the grant each cycle.
REQ-034 mode=0, sel=3, in_valid[3]=1, in_data[3]=8'hA5 -> out_data=A5, out_ch=3 one cycle later; sel=3 with in_valid[3]=0 -> no transfer.
REQ-035 out_valid=1 with out_ready held 0 for 4 cycles while all channels request -> out_data/out_ch stable and in_ready=0; on release, the next channel after the held one is served.
REQ-036 rst_n pulsed low mid-stream while out_valid=1 -> out_valid drops immediately (asynchronously); after release the first grant is channel 0.
REQ-037 NCH=5 (non-power-of-2), mode=0, sel=6 -> no grant; mode=1 with all channels requesting wraps 4->0.
